// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports plus the shared memory port seen by mem_port_arbiter.
// The slave modport is the arbiter side; master is requesters plus memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between fetch and data requesters, data first.
// Define MEM_ARB_STARVE_EN to add the fetch starvation guard (forced fetch after STARVE_MAX losses).
//
// state | meaning
// IDLE  | no access in flight, arbitrate each edge
// ISSUE | memory strobe and grant pulse for the captured request
// WAIT  | count down memory read latency
// RESP  | valid pulse to the owner, arbitrate for the next access
module mem_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk1,
   input  logic              rst,
   mem_port_arbiter_if.slave bus,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic       OWN_IF = 1'b0;
   localparam logic       OWN_DM = 1'b1;
   localparam logic [1:0] LAT_LD = 2'(MEM_LAT - 1);

   if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be 1..4");
   end
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_MAX must be 1..15");
   end

   state_t     state, state_nxt;
   logic       owner, owner_nxt;
   logic       op_we;
   logic [1:0] lat_cnt;
   logic       rd_done;
   logic       grant_dm, grant_if;
   logic       starve_trip;
   logic       if_gnt_nxt, dm_gnt_nxt, if_valid_nxt, dm_valid_nxt;
   logic       mem_en_nxt, mem_we_nxt, busy_nxt;

   assign rd_done = (state == WAIT) && (lat_cnt == 2'd0);

`ifdef MEM_ARB_STARVE_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   logic [3:0] starve_cnt;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else if (grant_if)
         starve_cnt <= '0;
      else if (grant_dm && bus.if_req && (starve_cnt != 4'hF))
         starve_cnt <= starve_cnt + 4'd1;
   end

   // Qualified with if_req so a tripped count can never block data when no fetch is waiting.
   assign starve_trip = bus.if_req && (starve_cnt >= STARVE_LIM);
`else
   assign starve_trip = 1'b0;
`endif

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= OWN_IF;
         op_we         <= 1'b0;
         lat_cnt       <= '0;
         bus.if_gnt    <= 1'b0;
         bus.dm_gnt    <= 1'b0;
         bus.if_valid  <= 1'b0;
         bus.dm_valid  <= 1'b0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         busy          <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         bus.if_gnt   <= if_gnt_nxt;
         bus.dm_gnt   <= dm_gnt_nxt;
         bus.if_valid <= if_valid_nxt;
         bus.dm_valid <= dm_valid_nxt;
         bus.mem_en   <= mem_en_nxt;
         bus.mem_we   <= mem_we_nxt;
         busy         <= busy_nxt;

         if (grant_dm) begin
            op_we         <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
         end else if (grant_if) begin
            op_we        <= 1'b0;
            bus.mem_addr <= bus.if_addr;
         end

         if (state == ISSUE)
            lat_cnt <= LAT_LD;
         else if ((state == WAIT) && (lat_cnt != 2'd0))
            lat_cnt <= lat_cnt - 2'd1;

         // Stores leave dm_rdata untouched.
         if (rd_done && !op_we) begin
            if (owner == OWN_DM)
               bus.dm_rdata <= bus.mem_rdata;
            else
               bus.if_rdata <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      grant_dm  = 1'b0;
      grant_if  = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (bus.dm_req && !starve_trip) begin
               grant_dm  = 1'b1;
               owner_nxt = OWN_DM;
               state_nxt = ISSUE;
            end else if (bus.if_req) begin
               grant_if  = 1'b1;
               owner_nxt = OWN_IF;
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (rd_done) state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if_gnt_nxt   = grant_if;
      dm_gnt_nxt   = grant_dm;
      mem_en_nxt   = grant_if || grant_dm;
      mem_we_nxt   = grant_dm && bus.dm_we;
      if_valid_nxt = (state_nxt == RESP) && (owner == OWN_IF);
      dm_valid_nxt = (state_nxt == RESP) && (owner == OWN_DM);
      busy_nxt     = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=1 instance for function, MEM_LAT=3 for latency.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   logic busy1, busy3;

   always #5 clk1 = ~clk1;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b3 ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (b1),
      .busy (busy1)
   );

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (b3),
      .busy (busy3)
   );

   // memories behind each arbiter
   logic [DATA_W-1:0] mem1 [0:1023];
   logic [DATA_W-1:0] mem3 [0:1023];
   logic [DATA_W-1:0] ref_mem [0:1023];
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd3_0, rd3_1, rd3_2;

   always @(posedge clk1) begin
      if (b1.mem_en) begin
         rd1 <= mem1[b1.mem_addr];
         if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      end
   end
   assign b1.mem_rdata = rd1;

   always @(posedge clk1) begin
      if (b3.mem_en) begin
         rd3_0 <= mem3[b3.mem_addr];
         if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
      end
      rd3_1 <= rd3_0;
      rd3_2 <= rd3_1;
   end
   assign b3.mem_rdata = rd3_2;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   exp_t if_q[$];
   exp_t dm_q[$];
   int   cyc = 0;
   int   if_gcyc, dm_gcyc, if_vcyc, dm_vcyc;
   int   valid_seen = 0;
   bit   mon_en = 1'b0;
   logic [DATA_W-1:0] dm_rdata_exp = '0;

   always @(posedge clk1) cyc <= cyc + 1;

   always @(negedge clk1) begin
      if (!rst) begin
         if (b1.if_valid || b1.dm_valid) valid_seen++;
         if (mon_en) begin
            if (b1.if_gnt || b1.dm_gnt) begin
               check_val("gnt_exclusive", 32'(b1.if_gnt & b1.dm_gnt), 32'd0);
               check_val("gnt_valid_overlap", 32'(b1.if_valid | b1.dm_valid), 32'd0);
            end
            if (b1.if_gnt) begin
               if (if_q.size() == 0) check_val("if_gnt_unexpected", 32'(b1.if_gnt), 32'd0);
               else begin
                  check_val("if_mem_en_we", 32'({b1.mem_en, b1.mem_we}), 32'b10);
                  check_val("if_mem_addr", 32'(b1.mem_addr), 32'(if_q[0].addr));
                  if_gcyc = cyc;
               end
            end
            if (b1.dm_gnt) begin
               if (dm_q.size() == 0) check_val("dm_gnt_unexpected", 32'(b1.dm_gnt), 32'd0);
               else begin
                  check_val("dm_mem_en_we", 32'({b1.mem_en, b1.mem_we}), 32'({1'b1, dm_q[0].we}));
                  check_val("dm_mem_addr", 32'(b1.mem_addr), 32'(dm_q[0].addr));
                  if (dm_q[0].we) check_val("dm_mem_wdata", b1.mem_wdata, dm_q[0].data);
                  dm_gcyc = cyc;
               end
            end
            if (b1.if_valid) begin
               if (if_q.size() == 0) check_val("if_valid_unexpected", 32'(b1.if_valid), 32'd0);
               else begin
                  exp_t e;
                  e = if_q.pop_front();
                  if_vcyc = cyc;
                  check_val("if_latency", 32'(cyc - if_gcyc), 32'd2);
                  check_val("if_rdata", b1.if_rdata, e.data);
               end
            end
            if (b1.dm_valid) begin
               if (dm_q.size() == 0) check_val("dm_valid_unexpected", 32'(b1.dm_valid), 32'd0);
               else begin
                  exp_t e;
                  e = dm_q.pop_front();
                  dm_vcyc = cyc;
                  check_val("dm_latency", 32'(cyc - dm_gcyc), 32'd2);
                  if (e.we) check_val("dm_rdata_hold", b1.dm_rdata, dm_rdata_exp);
                  else begin
                     check_val("dm_rdata", b1.dm_rdata, e.data);
                     dm_rdata_exp = e.data;
                  end
               end
            end
         end
      end
   end

   task automatic do_fetch(input logic [ADDR_W-1:0] a);
      exp_t e;
      bit   got;
      e.we = 1'b0; e.addr = a; e.data = ref_mem[a];
      if_q.push_back(e);
      b1.if_addr = a;
      b1.if_req  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk1);
         got = b1.if_gnt;
      end
      b1.if_req = 1'b0;
      if (!got) check_val("if_gnt_timeout", 32'(got), 32'd1);
   endtask

   task automatic do_data(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_t e;
      bit   got;
      e.we = we; e.addr = a; e.data = we ? d : ref_mem[a];
      if (we) ref_mem[a] = d;
      dm_q.push_back(e);
      b1.dm_we    = we;
      b1.dm_addr  = a;
      b1.dm_wdata = d;
      b1.dm_req   = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk1);
         got = b1.dm_gnt;
      end
      b1.dm_req = 1'b0;
      if (!got) check_val("dm_gnt_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk1);
         done = (if_q.size() == 0) && (dm_q.size() == 0) && !busy1;
      end
      if (!done) check_val("drain_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   gseq [0:9];
      int   ng, tg, tv, nb;
      logic [DATA_W-1:0] rd;
      bit   got;

      for (int i = 0; i < 1024; i++) begin
         mem1[i]    = 32'hC0DE_0000 + 32'(i);
         ref_mem[i] = 32'hC0DE_0000 + 32'(i);
         mem3[i]    = 32'h0;
      end
      mem1[5]  = 32'h0420_0001; ref_mem[5]  = 32'h0420_0001;
      mem1[20] = 32'd7;         ref_mem[20] = 32'd7;
      mem3[12] = 32'h1234_5678;

      b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
      b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = '0; b3.dm_wdata = '0;

      // reset values
      repeat (3) @(negedge clk1);
      check_val("rst_ctrl", 32'({b1.if_gnt, b1.if_valid, b1.dm_gnt, b1.dm_valid, b1.mem_en, b1.mem_we, busy1}), 32'd0);
      check_val("rst_if_rdata", b1.if_rdata, 32'd0);
      check_val("rst_dm_rdata", b1.dm_rdata, 32'd0);
      check_val("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk1);

      // single fetch
      do_fetch(10'd5);
      wait_idle();
      check_val("fetch_dm_rdata_zero", b1.dm_rdata, 32'd0);
      check_val("fetch_if_rdata_held", b1.if_rdata, 32'h0420_0001);

      // simultaneous fetch and load: data first, fetch granted in RESP
      fork
         do_fetch(10'd8);
         do_data(1'b0, 10'd20, 32'd0);
      join
      wait_idle();
      check_val("fetch_after_dm", 32'(if_vcyc - dm_vcyc), 32'd3);

      // store then load back
      do_data(1'b1, 10'd30, 32'hDEAD_BEEF);
      wait_idle();
      do_data(1'b0, 10'd30, 32'd0);
      wait_idle();

      // continuous contention
      mon_en = 1'b0;
      b1.dm_we = 1'b0; b1.dm_addr = 10'd40; b1.dm_req = 1'b1;
      b1.if_addr = 10'd41; b1.if_req = 1'b1;
      ng = 0;
      for (int i = 0; i < 150 && ng < 10; i++) begin
         @(negedge clk1);
         if (b1.if_gnt || b1.dm_gnt) begin
            gseq[ng] = b1.if_gnt;
            ng++;
         end
      end
      b1.dm_req = 1'b0;
      b1.if_req = 1'b0;
      check_val("starve_grant_count", 32'(ng), 32'd10);
      for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_STARVE_EN
         check_val($sformatf("starve_grant%0d", i), 32'(gseq[i]), 32'((i % 5) == 4));
`else
         check_val($sformatf("starve_grant%0d", i), 32'(gseq[i]), 32'd0);
`endif
      end
      wait_idle();
      dm_rdata_exp = ref_mem[40];
      mon_en = 1'b1;

      // MEM_LAT=3 instance
      b3.dm_we = 1'b0; b3.dm_addr = 10'd12; b3.dm_req = 1'b1;
      tg = -100; tv = -1; nb = 0; rd = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk1);
         if (b3.dm_gnt) begin tg = i; b3.dm_req = 1'b0; end
         if (b3.dm_valid) begin tv = i; rd = b3.dm_rdata; end
         if (busy3) nb++;
      end
      b3.dm_req = 1'b0;
      check_val("lat3_gnt_to_valid", 32'(tv - tg), 32'd4);
      check_val("lat3_busy_cycles", 32'(nb), 32'd5);
      check_val("lat3_rdata", rd, 32'h1234_5678);

      // reset during WAIT
      mon_en = 1'b0;
      b1.dm_we = 1'b0; b1.dm_addr = 10'd20; b1.dm_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk1);
         got = b1.dm_gnt;
      end
      b1.dm_req = 1'b0;
      check_val("rstmid_gnt_seen", 32'(got), 32'd1);
      @(posedge clk1);
      #2 rst = 1'b1;
      #1;
      check_val("rstmid_ctrl", 32'({b1.if_gnt, b1.if_valid, b1.dm_gnt, b1.dm_valid, b1.mem_en, b1.mem_we, busy1}), 32'd0);
      check_val("rstmid_dm_rdata", b1.dm_rdata, 32'd0);
      check_val("rstmid_if_rdata", b1.if_rdata, 32'd0);
      @(negedge clk1);
      rst = 1'b0;
      valid_seen = 0;
      repeat (6) @(negedge clk1);
      check_val("rstmid_no_stale_valid", 32'(valid_seen), 32'd0);
      check_val("rstmid_idle", 32'(busy1), 32'd0);

      // recovery access after reset
      if_q.delete();
      dm_q.delete();
      dm_rdata_exp = '0;
      mon_en = 1'b1;
      do_fetch(10'd5);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
